// File: rtl/man_encoding_master.sv
// -----------------------------------------------------------------------------
// man_encoding_master
//
// Manchester transmitter for the master-call side of the AS-i link. A request
// latches a control bit, a 5-bit slave address and 5 information bits into a
// 14-bit master frame, which is then sent MSB first at one bit per
// 2*HALF_CYC clocks. The frame layout is:
//   ST=0, CB, A4..A0, I4..I0, PB (even parity over CB..I0), EB=1
// Each bit b is sent as ~b for the first half-bit and b for the second half-bit.
//
// Optional feature macro: MAN_ENC_PAUSE_EN
//   When defined, a master pause of PAUSE_BITS bit times, with the line held
//   high, follows the end bit. tx_busy stays high through the pause and
//   tx_done marks its end. When undefined, the block goes straight back to
//   IDLE after the end bit, and tx_done coincides with rx_open.
//
// Parameters:
//   HALF_CYC    clocks per Manchester half-bit (36 = 3 us at 12 MHz)
//   FRAME_BITS  bits per master frame (14)
//   PAUSE_BITS  bit times of master pause (only with MAN_ENC_PAUSE_EN)
//
// Ports:
//   clk_in      system clock, 12 MHz
//   rst         asynchronous, active-low reset
//   start       request to send, sampled only in IDLE
//   ctrl_bit    control bit CB
//   addr[4:0]   slave address A4..A0
//   info[4:0]   information bits I4..I0
//   manchester  registered encoded line, idle level 1
//   tx_busy     high while a frame (and pause, if enabled) is in progress
//   tx_done     one-cycle pulse when the block returns to IDLE
//   rx_open     one-cycle pulse on the cycle after the last half-bit of EB
// -----------------------------------------------------------------------------
module man_encoding_master #(
  parameter int HALF_CYC   = 36,
  parameter int FRAME_BITS = 14
`ifdef MAN_ENC_PAUSE_EN
  ,
  parameter int PAUSE_BITS = 3
`endif
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  input  logic       ctrl_bit,
  input  logic [4:0] addr,
  input  logic [4:0] info,
  output logic       manchester,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       rx_open
);

`ifdef MAN_ENC_PAUSE_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    PAUSE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1
  } state_t;
`endif

  localparam logic [5:0] HALF_LAST = 6'(HALF_CYC - 1);
  localparam logic [3:0] BIT_LAST  = 4'(FRAME_BITS - 1);
`ifdef MAN_ENC_PAUSE_EN
  localparam logic [8:0] PAUSE_LAST = 9'(PAUSE_BITS * 2 * HALF_CYC - 1);
`endif

  state_t      state;
  logic [13:0] shreg;
  logic [5:0]  half_cnt;
  logic        half_sel;
  logic [3:0]  bit_cnt;
  logic        end_pend;
`ifdef MAN_ENC_PAUSE_EN
  logic [8:0]  pause_cnt;
`endif

  logic        parity;
  logic [13:0] frame_load;

  // Even parity over CB, address and information bits, so the number of ones
  // over CB..PB is always even.
  assign parity     = ^{ctrl_bit, addr, info};
  assign frame_load = {1'b0, ctrl_bit, addr, info, parity, 1'b1};

  // Transmit sequencer. All outputs are registered and reflect the state the
  // sequencer was in on the previous cycle, which gives the one-clock latency
  // from the start request to the first half of ST. end_pend carries the
  // "frame finished" event from the last SEND/PAUSE cycle into the first IDLE
  // cycle, so tx_done (and rx_open without a pause) lands on the same edge
  // that tx_busy falls. The last half of EB is already 1, so returning to the
  // idle level causes no glitch on the line.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      half_cnt   <= '0;
      half_sel   <= 1'b0;
      bit_cnt    <= '0;
      end_pend   <= 1'b0;
`ifdef MAN_ENC_PAUSE_EN
      pause_cnt  <= '0;
`endif
      manchester <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      rx_open    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      rx_open <= 1'b0;

      case (state)
        IDLE: begin
          manchester <= 1'b1;
          tx_busy    <= 1'b0;
          if (end_pend) begin
            tx_done  <= 1'b1;
`ifndef MAN_ENC_PAUSE_EN
            rx_open  <= 1'b1;
`endif
            end_pend <= 1'b0;
          end
          if (start) begin
            shreg    <= frame_load;
            half_cnt <= '0;
            half_sel <= 1'b0;
            bit_cnt  <= '0;
            state    <= SEND;
          end
        end

        SEND: begin
          tx_busy    <= 1'b1;
          manchester <= half_sel ? shreg[13] : ~shreg[13];
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            half_sel <= ~half_sel;
            if (half_sel) begin
              shreg <= {shreg[12:0], 1'b0};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt   <= '0;
`ifdef MAN_ENC_PAUSE_EN
                pause_cnt <= '0;
                state     <= PAUSE;
`else
                end_pend  <= 1'b1;
                state     <= IDLE;
`endif
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end else begin
            half_cnt <= half_cnt + 6'd1;
          end
        end

`ifdef MAN_ENC_PAUSE_EN
        // The first pause cycle is the cycle right after EB's last half-bit,
        // which is where the slave-response window opens.
        PAUSE: begin
          tx_busy    <= 1'b1;
          manchester <= 1'b1;
          rx_open    <= (pause_cnt == 9'd0);
          if (pause_cnt == PAUSE_LAST) begin
            pause_cnt <= '0;
            end_pend  <= 1'b1;
            state     <= IDLE;
          end else begin
            pause_cnt <= pause_cnt + 9'd1;
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
